mbinit_sb_tx_queue: RTL and testbench

Sideband transmit queue for the MBINIT stage. It sits directly downstream of the MBINIT parameter-exchange wrapper and takes its encoded sideband message and valid. Each new message is buffered in a small FIFO and handed to the sideband serializer over a valid/ready handshake, with a minimum idle gap between messages. It generates the sideband busy level and the busy falling-edge pulse that the upstream TX/RX parameter FSMs use to pace their requests.

---
 rtl/mbinit_sb_tx_queue.sv | 160 ++++++++++++++++
 tb/tb_mbinit_sb_tx_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbinit_sb_tx_queue.sv
// MBINIT sideband transmit queue: edge-detected push into a small FIFO, a single
// output register stage with valid/ready handshake, post-handshake idle gap and busy tracking.
module mbinit_sb_tx_queue #(
  parameter int SB_MSG_Width = 4,
  parameter int DEPTH        = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_MBINIT_en,
  input  logic                    i_msg_valid,
  input  logic [SB_MSG_Width-1:0] i_encoded_SB_msg,
  input  logic                    i_tx_ready,
  output logic                    o_tx_valid,
  output logic [SB_MSG_Width-1:0] o_tx_msg,
  output logic                    o_sb_busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_overflow
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES);

  logic [SB_MSG_Width-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [SB_MSG_Width-1:0] tx_msg_q, tx_msg_d;
  logic [3:0]              gap_cnt_q, gap_cnt_d;
  logic                    valid_prev_q, valid_prev_d;
  logic                    busy_prev_q, busy_prev_d;
  logic                    overflow_q, overflow_d;

  logic push_s;
  logic full_s;
  logic wr_en_s;
  logic load_s;
  logic hs_s;
  logic sb_busy_s;

  // Event decode; the full check deliberately uses the pre-edge count.
  always_comb begin
    push_s    = i_MBINIT_en & i_msg_valid & ~valid_prev_q;
    full_s    = (count_q == FULL_CNT);
    wr_en_s   = push_s & ~full_s;
    load_s    = i_MBINIT_en & ~tx_valid_q & (gap_cnt_q == 4'd0) & (count_q != CNT_ZERO);
    hs_s      = tx_valid_q & i_tx_ready;
    sb_busy_s = (count_q != CNT_ZERO) | tx_valid_q | (gap_cnt_q != 4'd0);
  end

  // Next-state logic; a low enable flushes everything except overflow and the last message.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tx_valid_d   = tx_valid_q;
    tx_msg_d     = tx_msg_q;
    gap_cnt_d    = gap_cnt_q;
    valid_prev_d = valid_prev_q;
    busy_prev_d  = busy_prev_q;
    overflow_d   = overflow_q;
    if (!i_MBINIT_en) begin
      wr_ptr_d     = PTR_ZERO;
      rd_ptr_d     = PTR_ZERO;
      count_d      = CNT_ZERO;
      tx_valid_d   = 1'b0;
      gap_cnt_d    = 4'd0;
      valid_prev_d = 1'b0;
      // Cleared so re-enabling after a flush cannot produce a spurious busy-fall pulse.
      busy_prev_d  = 1'b0;
    end else begin
      valid_prev_d = i_msg_valid;
      busy_prev_d  = sb_busy_s;
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, load_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push_s && full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (load_s) begin
        tx_valid_d = 1'b1;
        tx_msg_d   = mem_q[rd_ptr_q];
      end else if (hs_s) begin
        tx_valid_d = 1'b0;
      end else begin
        tx_valid_d = tx_valid_q;
      end
      if (hs_s) begin
        gap_cnt_d = GAP_LOAD;
      end else if (gap_cnt_q != 4'd0) begin
        gap_cnt_d = gap_cnt_q - 4'd1;
      end else begin
        gap_cnt_d = gap_cnt_q;
      end
    end
  end

  // Control and output register bank.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      tx_valid_q   <= 1'b0;
      tx_msg_q     <= {SB_MSG_Width{1'b0}};
      gap_cnt_q    <= 4'd0;
      valid_prev_q <= 1'b0;
      busy_prev_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_valid_q   <= tx_valid_d;
      tx_msg_q     <= tx_msg_d;
      gap_cnt_q    <= gap_cnt_d;
      valid_prev_q <= valid_prev_d;
      busy_prev_q  <= busy_prev_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {SB_MSG_Width{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= i_encoded_SB_msg;
    end
  end

  assign o_tx_valid          = tx_valid_q;
  assign o_tx_msg            = tx_msg_q;
  assign o_overflow          = overflow_q;
  assign o_sb_busy           = sb_busy_s;
  assign o_falling_edge_busy = busy_prev_q & ~sb_busy_s & i_MBINIT_en;

endmodule

// File: tb/tb_mbinit_sb_tx_queue.sv
// Directed self-checking bench for mbinit_sb_tx_queue (DEPTH=4, GAP_CYCLES=2).
module tb_mbinit_sb_tx_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mv;
  logic [3:0] msg;
  logic       rdy;
  logic       tv;
  logic [3:0] tm;
  logic       busy;
  logic       feb;
  logic       ovf;

  int         n_cmp = 0;
  int         n_err = 0;
  int         hs;
  int         maxc;
  int         nrx;
  logic [3:0] rx [8];

  mbinit_sb_tx_queue #(
    .SB_MSG_Width(4),
    .DEPTH(4),
    .GAP_CYCLES(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_MBINIT_en(en),
    .i_msg_valid(mv),
    .i_encoded_SB_msg(msg),
    .i_tx_ready(rdy),
    .o_tx_valid(tv),
    .o_tx_msg(tm),
    .o_sb_busy(busy),
    .o_falling_edge_busy(feb),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    mv  = 1'b1;
    msg = m;
    step();
    mv  = 1'b0;
    step();
  endtask

  task automatic collect(input int budget);
    nrx = 0;
    for (int i = 0; i < budget; i++) begin
      if (tv && rdy) begin
        if (nrx < 8) rx[nrx] = tm;
        nrx++;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mv = 1'b0; msg = 4'd0; rdy = 1'b0;
    step(); step();
    chk("rst_tx_valid", 32'(tv), 32'd0);
    chk("rst_tx_msg",   32'(tm), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_feb",      32'(feb), 32'd0);
    chk("rst_ovf",      32'(ovf), 32'd0);
    rst = 1'b0; en = 1'b1;
    step();

    // Single message
    mv = 1'b1; msg = 4'h3; rdy = 1'b1;
    step();
    chk("s1_busy_after_push", 32'(busy), 32'd1);
    chk("s1_tv_after_push",   32'(tv), 32'd0);
    mv = 1'b0;
    step();
    chk("s1_tv_load",  32'(tv), 32'd1);
    chk("s1_tm_load",  32'(tm), 32'h3);
    step();
    chk("s1_tv_after_hs", 32'(tv), 32'd0);
    chk("s1_busy_gap1",   32'(busy), 32'd1);
    chk("s1_feb_gap1",    32'(feb), 32'd0);
    chk("s1_tm_hold",     32'(tm), 32'h3);
    step();
    chk("s1_busy_gap2",   32'(busy), 32'd1);
    step();
    chk("s1_busy_fall",   32'(busy), 32'd0);
    chk("s1_feb_pulse",   32'(feb), 32'd1);
    step();
    chk("s1_feb_once",    32'(feb), 32'd0);

    // Held valid
    hs = 0; maxc = 0;
    mv = 1'b1; msg = 4'h5;
    for (int i = 0; i < 10; i++) begin
      if (tv && rdy) hs++;
      step();
      if (int'(dut.count_q) > maxc) maxc = int'(dut.count_q);
    end
    mv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tv && rdy) hs++;
      step();
      if (int'(dut.count_q) > maxc) maxc = int'(dut.count_q);
    end
    chk("held_handshakes", 32'(hs), 32'd1);
    chk("held_max_count",  32'(maxc), 32'd1);
    chk("held_tm",         32'(tm), 32'h5);
    chk("held_idle",       32'(busy), 32'd0);

    // Overflow
    rdy = 1'b0;
    for (int k = 1; k <= 5; k++) pulse(4'(k));
    chk("ovf_not_yet", 32'(ovf), 32'd0);
    chk("ovf_tv_head", 32'(tv), 32'd1);
    chk("ovf_tm_head", 32'(tm), 32'h1);
    chk("ovf_count4",  32'(dut.count_q), 32'd4);
    pulse(4'h6);
    chk("ovf_set",     32'(ovf), 32'd1);
    rdy = 1'b1;
    collect(40);
    chk("ovf_drain_n", 32'(nrx), 32'd5);
    for (int k = 0; k < 5; k++) chk("ovf_order", 32'(rx[k]), 32'(k + 1));
    chk("ovf_sticky",  32'(ovf), 32'd1);
    chk("ovf_idle",    32'(busy), 32'd0);

    // Simultaneous push and load
    rdy = 1'b0;
    pulse(4'h7);
    pulse(4'h8);
    pulse(4'h9);
    chk("sim_count_pre", 32'(dut.count_q), 32'd2);
    chk("sim_tm_pre",    32'(tm), 32'h7);
    rdy = 1'b1;
    step();
    step();
    step();
    chk("sim_tv_gap_done", 32'(tv), 32'd0);
    chk("sim_count_mid",   32'(dut.count_q), 32'd2);
    mv = 1'b1; msg = 4'hA;
    step();
    chk("sim_count_post", 32'(dut.count_q), 32'd2);
    chk("sim_tv_post",    32'(tv), 32'd1);
    chk("sim_tm_post",    32'(tm), 32'h8);
    mv = 1'b0;
    collect(30);
    chk("sim_drain_n", 32'(nrx), 32'd3);
    chk("sim_order0",  32'(rx[0]), 32'h8);
    chk("sim_order1",  32'(rx[1]), 32'h9);
    chk("sim_order2",  32'(rx[2]), 32'hA);

    // Flush
    rdy = 1'b0;
    for (int k = 1; k <= 4; k++) pulse(4'(k));
    chk("fl_tv_pre",    32'(tv), 32'd1);
    chk("fl_count_pre", 32'(dut.count_q), 32'd3);
    en = 1'b0;
    #1;
    chk("fl_feb_low_en", 32'(feb), 32'd0);
    step();
    en = 1'b1;
    #1;
    chk("fl_tv",   32'(tv), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_feb",  32'(feb), 32'd0);
    chk("fl_ovf",  32'(ovf), 32'd1);
    chk("fl_tm",   32'(tm), 32'h1);
    step();
    chk("fl_tv_after",  32'(tv), 32'd0);
    chk("fl_feb_after", 32'(feb), 32'd0);

    // Async reset mid-gap
    rdy = 1'b1;
    pulse(4'hC);
    step();
    chk("ar_busy_gap", 32'(busy), 32'd1);
    chk("ar_tv_gap",   32'(tv), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("ar_tv",   32'(tv), 32'd0);
    chk("ar_tm",   32'(tm), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_feb",  32'(feb), 32'd0);
    chk("ar_ovf",  32'(ovf), 32'd0);
    #1 rst = 1'b0;
    step();
    mv = 1'b1; msg = 4'h3;
    step();
    chk("ar_s1_busy", 32'(busy), 32'd1);
    mv = 1'b0;
    step();
    chk("ar_s1_tv", 32'(tv), 32'd1);
    chk("ar_s1_tm", 32'(tm), 32'h3);
    step();
    chk("ar_s1_hs", 32'(tv), 32'd0);
    step();
    step();
    chk("ar_s1_fall", 32'(busy), 32'd0);
    chk("ar_s1_feb",  32'(feb), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
